// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory addressing and a 2-entry fetch queue.
// Optional FETCH_MISALIGN_TRAP_EN makes a misaligned redirect set a sticky error and halt fetch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic               misalign_err
);

  logic [31:0] pc_q;
  logic [31:0] ent_pc_q   [2];
  logic [31:0] ent_inst_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;
  logic        halted;
  logic [31:0] redirect_target;
  logic        pop;
  logic        push;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_q;

  assign misaligned      = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_target = misaligned ? redirect_pc : {redirect_pc[31:2], 2'b00};

  // Sticky until reset; an aligned redirect afterwards does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (misaligned) begin
      err_q <= 1'b1;
    end
  end

  assign halted       = err_q;
  assign misalign_err = err_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign halted               = 1'b0;
  assign misalign_err         = 1'b0;
`endif

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign id_valid  = (count_q != 2'd0);
  assign id_inst   = ent_inst_q[rd_ptr_q];
  assign id_pc     = ent_pc_q[rd_ptr_q];

  assign pop  = id_valid && id_ready;
  // Gated on the registered count only: a full queue never accepts a push, even with a pop.
  assign push = fetch_en && (count_q < 2'd2) && !redirect_valid && !halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        ent_pc_q[i]   <= 32'h0;
        ent_inst_q[i] <= 32'h0;
      end
    end else if (redirect_valid) begin
      pc_q     <= redirect_target;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        ent_pc_q[wr_ptr_q]   <= pc_q;
        ent_inst_q[wr_ptr_q] <= imem_data;
        wr_ptr_q             <= ~wr_ptr_q;
        pc_q                 <= pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps plus random traffic against a queue-based model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        misalign_err;

  logic [31:0] mem [64];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_qpc   [$];
  logic [31:0] m_qinst [$];
  logic        m_err;
  logic        m_halt;

  int n_total = 0;
  int n_pass  = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (6)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_qpc.delete();
    m_qinst.delete();
    m_err  = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic model_edge();
    logic do_pop;
    logic do_push;
    if (redirect_valid) begin
      m_qpc.delete();
      m_qinst.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_err  = 1'b1;
        m_halt = 1'b1;
        m_pc   = redirect_pc;
      end else begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end
`else
      m_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      do_pop  = (m_qpc.size() != 0) && id_ready;
      do_push = fetch_en && (m_qpc.size() < 2) && !m_halt;
      if (do_pop) begin
        void'(m_qpc.pop_front());
        void'(m_qinst.pop_front());
      end
      if (do_push) begin
        m_qpc.push_back(m_pc);
        m_qinst.push_back(mem[(m_pc / 4) % 64]);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_qpc.size() != 0});
    check({tag, ".imem_addr"}, {26'b0, imem_addr}, (m_pc / 4) % 64);
    check({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_err});
    if (m_qpc.size() != 0) begin
      check({tag, ".id_pc"}, id_pc, m_qpc[0]);
      check({tag, ".id_inst"}, id_inst, m_qinst[0]);
    end
  endtask

  task automatic step(input string tag, input logic fe, input logic rdy, input logic rv,
                      input logic [31:0] rpc);
    fetch_en       = fe;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();

    #12;
    check("reset.id_valid", {31'b0, id_valid}, 32'h0);
    check("reset.id_inst", id_inst, 32'h0);
    check("reset.id_pc", id_pc, 32'h0);
    check("reset.misalign_err", {31'b0, misalign_err}, 32'h0);
    check("reset.imem_addr", {26'b0, imem_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with decode always ready
    for (int i = 0; i < 8; i++) step("stream", 1'b1, 1'b1, 1'b0, 32'h0);

    // Stall decode: queue fills and pc holds
    for (int i = 0; i < 5; i++) step("stall", 1'b1, 1'b0, 1'b0, 32'h0);
    check("stall.full_pc_hold", {26'b0, imem_addr}, (m_pc / 4) % 64);
    for (int i = 0; i < 6; i++) step("resume", 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while full
    for (int i = 0; i < 3; i++) step("fill", 1'b1, 1'b0, 1'b0, 32'h0);
    step("redir10", 1'b1, 1'b1, 1'b1, 32'h0000_0010);
    check("redir10.flushed", {31'b0, id_valid}, 32'h0);
    step("redir10.n1", 1'b1, 1'b1, 1'b0, 32'h0);
    check("redir10.target_pc", id_pc, 32'h0000_0010);
    check("redir10.target_inst", id_inst, mem[4]);
    for (int i = 0; i < 3; i++) step("after10", 1'b1, 1'b1, 1'b0, 32'h0);

    // Word-address wrap across 0x100
    step("redirF0", 1'b1, 1'b1, 1'b1, 32'h0000_00F0);
    for (int i = 0; i < 6; i++) step("wrap", 1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect, then an aligned one
    step("redir0A", 1'b1, 1'b1, 1'b1, 32'h0000_000A);
    for (int i = 0; i < 5; i++) step("mis", 1'b1, 1'b1, 1'b0, 32'h0);
    step("redir20", 1'b1, 1'b1, 1'b1, 32'h0000_0020);
    for (int i = 0; i < 4; i++) step("post20", 1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("areset.id_valid", {31'b0, id_valid}, 32'h0);
    check("areset.imem_addr", {26'b0, imem_addr}, 32'h0);
    check("areset.misalign_err", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("restart", 1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic with occasional aligned redirects
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0), ($urandom & 32'hFFFF_FFFC));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
